// File: rtl/blk_mem_responder_pkg.sv
// Shared types and widths for the line-transfer memory responder.
package blk_mem_responder_pkg;
  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } state_t;
endpackage

// File: rtl/blk_mem_array.sv
// Single-port line RAM with registered read data, shaped for block-RAM inference.
import blk_mem_responder_pkg::*;

module blk_mem_array #(
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);
  logic [LINE_W-1:0] mem [2**IDX_W];

  always_ff @(posedge clk)
    if (en && we) mem[idx] <= wdata;

  // Read register only moves on reads, so it holds the last read line across writes.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)           rdata <= '0;
    else if (en && !we)   rdata <= mem[idx];
endmodule

// File: rtl/blk_mem_responder.sv
// Fixed-latency line memory responder: IDLE -> BUSY -> RESP -> GAP, registered outputs.
import blk_mem_responder_pkg::*;

module blk_mem_responder #(
  parameter int LATENCY = 8,
  parameter int IDX_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              proto_err
);
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t              state, nxt;
  logic [7:0]          cnt;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                req;
  logic                ram_en, ram_we;
  logic [IDX_W-1:0]    ram_idx;
  logic [LINE_W-1:0]   ram_wdata;
  logic                ready_d, busy_d, err_d;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req) nxt = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt == 8'd1) nxt = RESP;
      RESP:    nxt = GAP;
      GAP:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // RAM access happens on the edge entering RESP; with LATENCY=1 that is the
  // acceptance edge itself, so IDLE steers the live request into the RAM.
  always_comb begin
    ready_d   = (nxt == RESP);
    busy_d    = (nxt == BUSY) || (nxt == RESP);
    ram_en    = (nxt == RESP) && rst_n;
    ram_we    = (state == IDLE) ? mem_write : wr_q;
    ram_idx   = (state == IDLE) ? mem_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];
    ram_wdata = (state == IDLE) ? mem_wdata : wdata_q;
    err_d     = ((state == IDLE) && mem_read && mem_write) ||
                ((state == BUSY) && ((mem_addr != addr_q) || !req));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      mem_ready <= ready_d;
      busy      <= busy_d;
      if (err_d) proto_err <= 1'b1;
      if ((state == IDLE) && req) begin
        wr_q    <= mem_write;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        cnt     <= LAT_M1;
      end else if (state == BUSY) begin
        cnt <= cnt - 8'd1;
      end
    end

  blk_mem_array #(.IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (mem_rdata)
  );
endmodule
